// File: rtl/apb_bridge_pkg.sv
// -----------------------------------------------------------------------------
// apb_bridge_pkg
// Shared definitions for the AHB-Lite to APB bridge: FSM state encoding,
// AHB HTRANS encodings and HRESP response codes.
// -----------------------------------------------------------------------------
package apb_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage : apb_bridge_pkg

// File: rtl/apb_resp_mux.sv
// -----------------------------------------------------------------------------
// apb_resp_mux
// Purely combinational selection of the addressed APB slave's response.
// Ports:
//   i_idx      - slave index of the transfer in flight
//   i_prdata   - concatenated slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
//   i_pready   - per-slave ready
//   i_pslverr  - per-slave error
//   o_prdata   - read data of the selected slave
//   o_pready   - ready of the selected slave
//   o_pslverr  - error of the selected slave
// An index with no matching slave yields all-zero outputs.
// -----------------------------------------------------------------------------
module apb_resp_mux #(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_W      = 2
) (
  input  logic [SEL_W-1:0]                 i_idx,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] i_prdata,
  input  logic [NUM_SLAVES-1:0]            i_pready,
  input  logic [NUM_SLAVES-1:0]            i_pslverr,
  output logic [DATA_WIDTH-1:0]            o_prdata,
  output logic                             o_pready,
  output logic                             o_pslverr
);

  // NOTE: every output gets a default before the loop so no path leaves a
  // value unassigned; otherwise synthesis infers a latch.
  always_comb begin
    o_prdata  = '0;
    o_pready  = 1'b0;
    o_pslverr = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (i_idx == SEL_W'(i)) begin
        o_prdata  = i_prdata[i*DATA_WIDTH +: DATA_WIDTH];
        o_pready  = i_pready[i];
        o_pslverr = i_pslverr[i];
      end
    end
  end

endmodule : apb_resp_mux

// File: rtl/ahb_apb_bridge.sv
// -----------------------------------------------------------------------------
// ahb_apb_bridge
// AHB-Lite slave to APB master bridge. Each AHB single transfer becomes one
// APB SETUP/ACCESS sequence; the target slave is decoded from
// HADDR[SEL_LSB +: SEL_W]. PSLVERR or an out-of-range slave index produces the
// two-cycle AHB ERROR response.
// Ports:
//   PCLK, PRESET                 - shared clock, asynchronous active-high reset
//   HSEL/HADDR/HTRANS/HWRITE/
//   HWDATA/HREADY                - AHB-Lite slave inputs
//   HREADYOUT/HRESP/HRDATA       - AHB-Lite slave responses (registered)
//   PSEL/PENABLE/PWRITE/PADDR/
//   PWDATA                       - APB master outputs
//   PRDATA/PREADY/PSLVERR        - per-slave APB responses
// -----------------------------------------------------------------------------
module ahb_apb_bridge
  import apb_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_LSB    = 12
) (
  input  logic                             PCLK,
  input  logic                             PRESET,
  input  logic                             HSEL,
  input  logic [ADDR_WIDTH-1:0]            HADDR,
  input  logic [1:0]                       HTRANS,
  input  logic                             HWRITE,
  input  logic [DATA_WIDTH-1:0]            HWDATA,
  input  logic                             HREADY,
  output logic                             HREADYOUT,
  output logic                             HRESP,
  output logic [DATA_WIDTH-1:0]            HRDATA,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [SEL_W:0] NUM_SLV_W = (SEL_W + 1)'(NUM_SLAVES);

  state_t                  r_state;
  logic [SEL_W-1:0]        r_idx;
  logic [ADDR_WIDTH-1:0]   r_paddr;
  logic                    r_pwrite;
  logic [DATA_WIDTH-1:0]   r_hrdata;
  logic                    r_hreadyout;
  logic                    r_hresp;
  logic [NUM_SLAVES-1:0]   r_psel;
  logic                    r_penable;

  logic                    w_accept;
  logic [SEL_W-1:0]        w_new_idx;
  logic                    w_idx_ok;
  logic [NUM_SLAVES-1:0]   w_onehot;
  logic [DATA_WIDTH-1:0]   w_prdata;
  logic                    w_pready;
  logic                    w_pslverr;

  // Only NONSEQ/SEQ start a transfer; IDLE and BUSY get a zero-wait OKAY.
  assign w_accept  = HSEL && HREADY &&
                     ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  assign w_new_idx = HADDR[SEL_LSB +: SEL_W];
  // When NUM_SLAVES is not a power of two, the top index codes decode to nothing.
  assign w_idx_ok  = ({1'b0, w_new_idx} < NUM_SLV_W);

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_onehot[i] = (w_new_idx == SEL_W'(i));
    end
  end

  apb_resp_mux #(
    .NUM_SLAVES (NUM_SLAVES),
    .DATA_WIDTH (DATA_WIDTH),
    .SEL_W      (SEL_W)
  ) u_resp_mux (
    .i_idx     (r_idx),
    .i_prdata  (PRDATA),
    .i_pready  (PREADY),
    .i_pslverr (PSLVERR),
    .o_prdata  (w_prdata),
    .o_pready  (w_pready),
    .o_pslverr (w_pslverr)
  );

  // NOTE: state and registered outputs use non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_hrdata    <= '0;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
      r_psel      <= '0;
      r_penable   <= 1'b0;
    end else begin
      case (r_state)
        // These states all end an AHB data phase, so a new address may be taken.
        ST_IDLE, ST_DONE, ST_ERR2: begin
          r_penable <= 1'b0;
          if (w_accept) begin
            r_paddr  <= HADDR;
            r_pwrite <= HWRITE;
            r_idx    <= w_new_idx;
            if (w_idx_ok) begin
              r_state     <= ST_SETUP;
              r_psel      <= w_onehot;
              r_hreadyout <= 1'b0;
              r_hresp     <= HRESP_OKAY;
            end else begin
              // Decode miss: straight to the error response, no APB cycle.
              r_state     <= ST_ERR1;
              r_psel      <= '0;
              r_hreadyout <= 1'b0;
              r_hresp     <= HRESP_ERROR;
            end
          end else begin
            r_state     <= ST_IDLE;
            r_psel      <= '0;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
          end
        end

        ST_SETUP: begin
          r_state   <= ST_ACCESS;
          r_penable <= 1'b1;
        end

        ST_ACCESS: begin
          if (w_pready) begin
            r_psel    <= '0;
            r_penable <= 1'b0;
            if (w_pslverr) begin
              r_state     <= ST_ERR1;
              r_hreadyout <= 1'b0;
              r_hresp     <= HRESP_ERROR;
            end else begin
              r_state     <= ST_DONE;
              r_hreadyout <= 1'b1;
              r_hresp     <= HRESP_OKAY;
              if (!r_pwrite) begin
                r_hrdata <= w_prdata;
              end
            end
          end
        end

        ST_ERR1: begin
          r_state     <= ST_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_ERROR;
        end

        default: begin
          r_state     <= ST_IDLE;
          r_psel      <= '0;
          r_penable   <= 1'b0;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_OKAY;
        end
      endcase
    end
  end

  // HWDATA is held by the master while HREADYOUT is low, so it is already
  // valid in SETUP and can be forwarded without a register.
  assign PWDATA = (r_pwrite && ((r_state == ST_SETUP) || (r_state == ST_ACCESS)))
                  ? HWDATA : '0;

  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;
  assign HRDATA    = r_hrdata;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;

endmodule : ahb_apb_bridge

// File: tb/tb_ahb_apb_bridge.sv
// -----------------------------------------------------------------------------
// tb_ahb_apb_bridge
// Directed bench for ahb_apb_bridge built with three APB slaves, so that slave
// index 3 (HADDR 0x3000) is a decode miss.
// -----------------------------------------------------------------------------
module tb_ahb_apb_bridge;
  import apb_bridge_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NS = 3;

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic              HSEL;
  logic [AW-1:0]     HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [DW-1:0]     HWDATA;
  logic              HREADY;
  logic              HREADYOUT;
  logic              HRESP;
  logic [DW-1:0]     HRDATA;
  logic [NS-1:0]     PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [AW-1:0]     PADDR;
  logic [DW-1:0]     PWDATA;
  logic [NS*DW-1:0]  PRDATA;
  logic [NS-1:0]     PREADY;
  logic [NS-1:0]     PSLVERR;

  logic [DW-1:0]     prdata_s0;
  logic [DW-1:0]     prdata_s1;
  logic [DW-1:0]     prdata_s2;

  int n_checks   = 0;
  int n_pass     = 0;
  int low_cycles = 0;

  assign PRDATA = {prdata_s2, prdata_s1, prdata_s0};

  always #5 PCLK = ~PCLK;

  ahb_apb_bridge #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_SLAVES (NS),
    .SEL_LSB    (12)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Advance one clock and settle 1ns past the edge; counts wait-state cycles.
  task automatic tick();
    @(posedge PCLK);
    #1;
    if (HREADYOUT === 1'b0) low_cycles++;
  endtask

  task automatic addr_phase(input logic [AW-1:0] a, input logic w);
    HSEL   = 1'b1;
    HTRANS = HTRANS_NONSEQ;
    HADDR  = a;
    HWRITE = w;
  endtask

  task automatic bus_idle();
    HSEL   = 1'b0;
    HTRANS = HTRANS_IDLE;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESET    = 1'b0;
    HSEL      = 1'b0;
    HADDR     = '0;
    HTRANS    = HTRANS_IDLE;
    HWRITE    = 1'b0;
    HWDATA    = '0;
    HREADY    = 1'b1;
    PREADY    = '0;
    PSLVERR   = '0;
    prdata_s0 = 32'hDEAD_0000;
    prdata_s1 = 32'h0000_0000;
    prdata_s2 = 32'hBEEF_2222;
    #2 PRESET = 1'b1;
    #2;

    // Reset values
    check("rst_hreadyout", HREADYOUT, 1'b1);
    check("rst_hresp",     HRESP,     1'b0);
    check("rst_hrdata",    HRDATA,    32'h0);
    check("rst_psel",      PSEL,      3'b000);
    check("rst_penable",   PENABLE,   1'b0);
    check("rst_paddr",     PADDR,     32'h0);
    check("rst_pwrite",    PWRITE,    1'b0);

    tick();
    PRESET = 1'b0;
    tick();

    // Write to timer control register, zero-wait slave 1; unselected slave 0
    // flags an error that must be ignored.
    addr_phase(32'h0000_1004, 1'b1);
    PREADY     = 3'b111;
    PSLVERR    = 3'b001;
    low_cycles = 0;
    tick();
    bus_idle();
    HWDATA = 32'h0000_0001;
    #1;
    check("wr_setup_psel",    PSEL,      3'b010);
    check("wr_setup_penable", PENABLE,   1'b0);
    check("wr_setup_paddr",   PADDR,     32'h0000_1004);
    check("wr_setup_pwrite",  PWRITE,    1'b1);
    check("wr_setup_pwdata",  PWDATA,    32'h0000_0001);
    check("wr_setup_hready",  HREADYOUT, 1'b0);
    tick();
    check("wr_access_penable", PENABLE,   1'b1);
    check("wr_access_psel",    PSEL,      3'b010);
    check("wr_access_pwdata",  PWDATA,    32'h0000_0001);
    check("wr_access_hready",  HREADYOUT, 1'b0);
    tick();
    check("wr_done_hready",  HREADYOUT,  1'b1);
    check("wr_done_hresp",   HRESP,      1'b0);
    check("wr_done_psel",    PSEL,       3'b000);
    check("wr_done_penable", PENABLE,    1'b0);
    check("wr_done_pwdata",  PWDATA,     32'h0);
    check("wr_done_hrdata",  HRDATA,     32'h0);
    check("wr_low_cycles",   low_cycles, 2);
    PSLVERR = 3'b000;
    tick();

    // Read with 3 wait states from slave 1
    addr_phase(32'h0000_1008, 1'b0);
    PREADY     = 3'b101;
    prdata_s1  = 32'h0000_00FF;
    low_cycles = 0;
    tick();
    bus_idle();
    check("rd_setup_psel", PSEL, 3'b010);
    tick();
    check("rd_wait1_penable", PENABLE, 1'b1);
    tick();
    check("rd_wait2_hready", HREADYOUT, 1'b0);
    tick();
    check("rd_wait3_penable", PENABLE, 1'b1);
    check("rd_wait3_paddr",   PADDR,   32'h0000_1008);
    tick();
    PREADY = 3'b010;
    check("rd_access4_hready", HREADYOUT, 1'b0);
    tick();
    check("rd_done_hready", HREADYOUT,  1'b1);
    check("rd_done_hresp",  HRESP,      1'b0);
    check("rd_done_hrdata", HRDATA,     32'h0000_00FF);
    check("rd_low_cycles",  low_cycles, 5);
    tick();

    // Slave error on a write to slave 2
    addr_phase(32'h0000_2010, 1'b1);
    tick();
    bus_idle();
    HWDATA  = 32'hA5A5_A5A5;
    PREADY  = 3'b100;
    PSLVERR = 3'b100;
    #1;
    check("serr_setup_psel",   PSEL,   3'b100);
    check("serr_setup_pwdata", PWDATA, 32'hA5A5_A5A5);
    tick();
    check("serr_access_penable", PENABLE, 1'b1);
    tick();
    check("serr_err1_hready",  HREADYOUT, 1'b0);
    check("serr_err1_hresp",   HRESP,     1'b1);
    check("serr_err1_psel",    PSEL,      3'b000);
    check("serr_err1_penable", PENABLE,   1'b0);
    tick();
    check("serr_err2_hready", HREADYOUT, 1'b1);
    check("serr_err2_hresp",  HRESP,     1'b1);
    check("serr_err2_hrdata", HRDATA,    32'h0000_00FF);
    PSLVERR = 3'b000;
    tick();

    // Decode error: index 3 with only three slaves
    addr_phase(32'h0000_3000, 1'b0);
    tick();
    bus_idle();
    check("derr_err1_psel",   PSEL,      3'b000);
    check("derr_err1_hready", HREADYOUT, 1'b0);
    check("derr_err1_hresp",  HRESP,     1'b1);
    check("derr_err1_penable", PENABLE,  1'b0);
    // New transfer issued during ERR2 is processed normally.
    addr_phase(32'h0000_1000, 1'b1);
    tick();
    check("derr_err2_hready", HREADYOUT, 1'b1);
    check("derr_err2_hresp",  HRESP,     1'b1);
    check("derr_err2_psel",   PSEL,      3'b000);

    // Back-to-back: write 0x1000 accepted in ERR2, then read 0x1008 in DONE
    tick();
    bus_idle();
    HWDATA    = 32'h0000_1234;
    PREADY    = 3'b010;
    prdata_s1 = 32'h5555_AAAA;
    #1;
    check("b2b_wr_setup_psel",  PSEL,  3'b010);
    check("b2b_wr_setup_paddr", PADDR, 32'h0000_1000);
    check("b2b_wr_setup_hresp", HRESP, 1'b0);
    tick();
    check("b2b_wr_access_penable", PENABLE, 1'b1);
    tick();
    check("b2b_wr_done_hready", HREADYOUT, 1'b1);
    addr_phase(32'h0000_1008, 1'b0);
    tick();
    bus_idle();
    check("b2b_rd_setup_psel",    PSEL,      3'b010);
    check("b2b_rd_setup_penable", PENABLE,   1'b0);
    check("b2b_rd_setup_paddr",   PADDR,     32'h0000_1008);
    check("b2b_rd_setup_pwrite",  PWRITE,    1'b0);
    check("b2b_rd_setup_pwdata",  PWDATA,    32'h0);
    check("b2b_rd_setup_hready",  HREADYOUT, 1'b0);
    tick();
    check("b2b_rd_access_penable", PENABLE, 1'b1);
    check("b2b_rd_access_paddr",   PADDR,   32'h0000_1008);
    tick();
    check("b2b_rd_done_hrdata", HRDATA,    32'h5555_AAAA);
    check("b2b_rd_done_hready", HREADYOUT, 1'b1);

    // Reset mid-access: slave 2 never ready, unselected slaves ready
    addr_phase(32'h0000_2000, 1'b0);
    PREADY = 3'b011;
    tick();
    bus_idle();
    tick();
    check("rstmid_access_penable", PENABLE, 1'b1);
    check("rstmid_access_psel",    PSEL,    3'b100);
    tick();
    check("rstmid_hold_penable", PENABLE,   1'b1);
    check("rstmid_hold_hready",  HREADYOUT, 1'b0);
    #2 PRESET = 1'b1;
    #1;
    check("rstmid_psel",    PSEL,      3'b000);
    check("rstmid_penable", PENABLE,   1'b0);
    check("rstmid_hready",  HREADYOUT, 1'b1);
    check("rstmid_hresp",   HRESP,     1'b0);
    check("rstmid_hrdata",  HRDATA,    32'h0);
    tick();
    PRESET = 1'b0;
    HSEL   = 1'b1;
    HTRANS = HTRANS_IDLE;
    tick();
    check("post_rst_idle_hready", HREADYOUT, 1'b1);
    check("post_rst_idle_hresp",  HRESP,     1'b0);
    check("post_rst_idle_psel",   PSEL,      3'b000);
    HTRANS = HTRANS_BUSY;
    tick();
    check("post_rst_busy_hready", HREADYOUT, 1'b1);
    check("post_rst_busy_psel",   PSEL,      3'b000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_ahb_apb_bridge

// File: doc/ahb_apb_bridge.md
Name: ahb_apb_bridge

Overview:
- AHB-Lite slave to APB master bridge feeding the PD0 APB peripherals, including the always-on timer and its siblings.
- Converts each AHB single transfer into one APB SETUP/ACCESS sequence.
- Decodes the target slave from address bits, muxes the slave responses back, and maps PSLVERR onto the AHB two-cycle ERROR response.

Parameters:
- DATA_WIDTH, 32, data bus width on both sides.
- ADDR_WIDTH, 32, address width on both sides.
- NUM_SLAVES, 4, number of APB slaves; PSEL vector width.
- SEL_LSB, 12, lowest HADDR bit of the slave index field. Field width is SEL_W = $clog2(NUM_SLAVES), minimum 1.

Ports:
- PCLK  in  1  single clock for both AHB and APB sides.
- PRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  bridge selected.
- HADDR  in  ADDR_WIDTH  AHB address.
- HTRANS  in  2  AHB transfer type; IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  AHB write.
- HWDATA  in  DATA_WIDTH  AHB write data; held stable by the master during wait states.
- HREADY  in  1  bus-level ready.
- HREADYOUT  out  1  bridge ready.
- HRESP  out  1  0=OKAY, 1=ERROR.
- HRDATA  out  DATA_WIDTH  registered read data.
- PSEL  out  NUM_SLAVES  one-hot slave select.
- PENABLE  out  1  APB access phase.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_WIDTH  APB address, registered.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  NUM_SLAVES*DATA_WIDTH  concatenated slave read data; slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- PREADY  in  NUM_SLAVES  per-slave ready.
- PSLVERR  in  NUM_SLAVES  per-slave error.

Behaviour:
- Reset values: state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, stored index=0. Reset asserted mid-transfer aborts immediately to these values.
- Accept condition: HSEL && HTRANS[1] && HREADY, sampled in state IDLE, DONE or ERR2. On accept, register HADDR→PADDR, HWRITE→PWRITE, and idx=HADDR[SEL_LSB +: SEL_W].
- If idx >= NUM_SLAVES, go to ERR1 with no APB activity. Otherwise go to SETUP.
- IDLE/BUSY transfers, or HSEL low: state goes to IDLE, zero-wait OKAY.
- SETUP: PSEL[idx]=1, PENABLE=0, HREADYOUT=0. Next state ACCESS unconditionally.
- ACCESS: PSEL[idx]=1, PENABLE=1, HREADYOUT=0. Hold while PREADY[idx]=0 (unbounded; no timeout).
  - On PREADY[idx]=1 && PSLVERR[idx]=0: go to DONE; if a read, HRDATA <= PRDATA slice idx.
  - On PREADY[idx]=1 && PSLVERR[idx]=1: go to ERR1; HRDATA is unchanged.
- DONE: HREADYOUT=1, HRESP=0, PSEL=0. Next state depends on the accept condition: SETUP (or ERR1) on a new accept, else IDLE.
- ERR1: HREADYOUT=0, HRESP=1. Next state ERR2.
- ERR2: HREADYOUT=1, HRESP=1. A new address accepted here is processed normally.
- PWDATA = HWDATA combinationally during SETUP/ACCESS of a write, else 0. This is valid in SETUP because HWDATA is stable while HREADYOUT=0.
- Latency: a zero-wait APB slave gives HREADYOUT low for 2 cycles (SETUP, ACCESS); the data phase completes in the 3rd cycle (DONE). Each slave wait state adds 1 cycle.
- Back-to-back transfers: a new transfer accepted in DONE enters SETUP on the next edge. There is never a cycle with PENABLE=1 and a changed PADDR.
- PSEL is one-hot or zero at all times. PENABLE=1 only in ACCESS.
- Unselected slaves' PREADY/PSLVERR/PRDATA are ignored.

Decomposition:
- Package apb_bridge_pkg contains:
  - state enum {IDLE, SETUP, ACCESS, DONE, ERR1, ERR2}
  - HTRANS encodings as localparams
  - HRESP_OKAY/HRESP_ERROR constants
- One sub-module, apb_resp_mux: selects PRDATA/PREADY/PSLVERR by idx (purely combinational, parameterised by NUM_SLAVES and DATA_WIDTH).
- FSM and registers stay in ahb_apb_bridge.

Test Plan:
- Write to the timer control register:
  - Stimulus: NONSEQ write HADDR=0x0000_1004, HWDATA=0x1, slave 1 zero-wait.
  - Response: PSEL=0b0010 with PADDR=0x1004, PWRITE=1, PWDATA=0x1 in SETUP, then PENABLE=1. HREADYOUT low exactly 2 cycles, HRESP=0.
- Read with wait states:
  - Stimulus: NONSEQ read HADDR=0x0000_1008; slave 1 holds PREADY=0 for 3 ACCESS cycles, then returns PRDATA=0x0000_00FF.
  - Response: HREADYOUT low 5 cycles, then HRDATA=0x0000_00FF with HREADYOUT=1.
- Slave error:
  - Stimulus: write to slave 2 with PREADY=1, PSLVERR=1.
  - Response: ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1). HRDATA unchanged.
- Decode error:
  - Stimulus: NUM_SLAVES=3, read HADDR=0x0000_3000.
  - Response: no PSEL asserted; two-cycle ERROR response.
- Back-to-back transfers:
  - Stimulus: write 0x1000 then read 0x1008 issued in the DONE cycle.
  - Response: second SETUP on the cycle immediately after DONE; PSEL stays one-hot and PENABLE drops for the SETUP.
- Reset mid-access:
  - Stimulus: assert PRESET during ACCESS.
  - Response: PSEL=0, PENABLE=0, HREADYOUT=1 immediately (asynchronous). An IDLE HTRANS after release gives an OKAY response.
